// File: rtl/conv1_buf_8b.sv
// 3x3 sliding-window line buffer for the conv1 stage: raster pixels in,
// registered row-major windows out for every fully populated position.
module conv1_buf_8b #(
   parameter int unsigned IMG_WIDTH  = 28,
   parameter int unsigned IMG_HEIGHT = 28,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   output logic [DATA_WIDTH-1:0] pixel_0,
   output logic [DATA_WIDTH-1:0] pixel_1,
   output logic [DATA_WIDTH-1:0] pixel_2,
   output logic [DATA_WIDTH-1:0] pixel_3,
   output logic [DATA_WIDTH-1:0] pixel_4,
   output logic [DATA_WIDTH-1:0] pixel_5,
   output logic [DATA_WIDTH-1:0] pixel_6,
   output logic [DATA_WIDTH-1:0] pixel_7,
   output logic [DATA_WIDTH-1:0] pixel_8,
   output logic                  valid_out_buf,
   output logic                  frame_done
);

   localparam int unsigned COL_W    = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT);
   // pixel_in acts as offset 0, so registered history covers offsets 1..2W+2
   localparam int unsigned SR_DEPTH = 2 * IMG_WIDTH + 2;
   localparam int unsigned W        = IMG_WIDTH;

   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [DATA_WIDTH-1:0] sr [SR_DEPTH];
   logic                  win_ok_c;
   logic                  last_c;

   assign win_ok_c = valid_in && (row >= ROW_W'(2)) && (col >= COL_W'(2));
   assign last_c   = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));

   // Raster position of the pixel being accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (valid_in) begin
         if (col == COL_W'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= last_c ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SR_DEPTH); i++) sr[i] <= '0;
      end else if (valid_in) begin
         sr[0] <= pixel_in;
         for (int i = 1; i < int'(SR_DEPTH); i++) sr[i] <= sr[i-1];
      end
   end

   // Window registers hold their last value between valid windows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_0       <= '0;
         pixel_1       <= '0;
         pixel_2       <= '0;
         pixel_3       <= '0;
         pixel_4       <= '0;
         pixel_5       <= '0;
         pixel_6       <= '0;
         pixel_7       <= '0;
         pixel_8       <= '0;
         valid_out_buf <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         valid_out_buf <= win_ok_c;
         frame_done    <= win_ok_c && last_c;
         if (win_ok_c) begin
            pixel_8 <= pixel_in;
            pixel_7 <= sr[0];
            pixel_6 <= sr[1];
            pixel_5 <= sr[W-1];
            pixel_4 <= sr[W];
            pixel_3 <= sr[W+1];
            pixel_2 <= sr[2*W-1];
            pixel_1 <= sr[2*W];
            pixel_0 <= sr[2*W+1];
         end
      end
   end

endmodule

// File: tb/tb_conv1_buf_8b.sv
// Self-checking bench for conv1_buf_8b against a 2-D frame model.
module tb_conv1_buf_8b;

   localparam int W = 28;
   localparam int H = 28;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_in = 1'b0;
   logic [7:0] pixel_in = 8'd0;
   logic [7:0] p [9];
   logic       valid_out_buf;
   logic       frame_done;

   int         tests = 0;
   int         fails = 0;
   int         r = 0;
   int         c = 0;
   int         pulses = 0;
   int         fds = 0;
   logic [7:0] img [H][W];
   logic [7:0] exp_win [9];
   logic       exp_v = 1'b0;
   logic       exp_fd = 1'b0;

   always #5 clk = ~clk;

   conv1_buf_8b dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
      .pixel_0(p[0]), .pixel_1(p[1]), .pixel_2(p[2]),
      .pixel_3(p[3]), .pixel_4(p[4]), .pixel_5(p[5]),
      .pixel_6(p[6]), .pixel_7(p[7]), .pixel_8(p[8]),
      .valid_out_buf(valid_out_buf), .frame_done(frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 9; k++) chk($sformatf("pixel_%0d", k), 32'(p[k]), 32'(exp_win[k]));
      chk("valid_out_buf", 32'(valid_out_buf), 32'(exp_v));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
   endtask

   task automatic model_reset();
      r = 0;
      c = 0;
      exp_v = 1'b0;
      exp_fd = 1'b0;
      for (int k = 0; k < 9; k++) exp_win[k] = 8'd0;
   endtask

   // Drive one cycle, update the frame model, then compare everything
   task automatic step(input logic v, input logic [7:0] d);
      valid_in = v;
      pixel_in = d;
      @(posedge clk);
      #1;
      exp_v = 1'b0;
      exp_fd = 1'b0;
      if (v) begin
         img[r][c] = d;
         if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  exp_win[3*i+j] = img[r-2+i][c-2+j];
            exp_v = 1'b1;
            exp_fd = (r == H-1) && (c == W-1);
         end
         c++;
         if (c == W) begin
            c = 0;
            r++;
            if (r == H) r = 0;
         end
      end
      if (valid_out_buf === 1'b1) pulses++;
      if (frame_done === 1'b1) fds++;
      check_all();
   endtask

   function automatic logic [7:0] pix(input int mode, input int idx);
      case (mode)
         0:       return 8'(idx);
         1:       return 8'($urandom);
         default: return 8'd255;
      endcase
   endfunction

   // mode 0 ramp, 1 random, 2 constant 255; gap_pct = idle probability
   task automatic frame(input int mode, input int gap_pct, input bit directed);
      pulses = 0;
      fds = 0;
      for (int idx = 0; idx < W*H; idx++) begin
         while (int'($urandom_range(99)) < gap_pct) step(1'b0, 8'($urandom));
         step(1'b1, pix(mode, idx));
         if (directed && idx == 58) begin
            chk("first_win_p0", 32'(p[0]), 32'd0);
            chk("first_win_p4", 32'(p[4]), 32'd29);
            chk("first_win_p8", 32'(p[8]), 32'd58);
         end
         if (directed && idx == 83) begin
            chk("rowend_p0", 32'(p[0]), 32'd25);
            chk("rowend_p5", 32'(p[5]), 32'd55);
         end
         if (directed && (idx == 84 || idx == 85))
            chk("rowwrap_novalid", 32'(valid_out_buf), 32'd0);
         if (directed && idx == W*H-1)
            chk("last_p8", 32'(p[8]), 32'd15);
      end
      chk("pulse_count", 32'(pulses), 32'd676);
      chk("frame_done_count", 32'(fds), 32'd1);
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      frame(0, 0, 1'b1);
      frame(0, 0, 1'b1);
      frame(0, 40, 1'b1);
      frame(1, 40, 1'b0);

      // Asynchronous reset part-way through a frame
      for (int idx = 0; idx < 300; idx++) step(1'b1, pix(1, idx));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;

      frame(1, 0, 1'b0);
      frame(2, 20, 1'b0);

      for (int k = 0; k < 4; k++) step(1'b0, 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
